// File: rtl/period_generator_if.sv
// Load port of the period generator: requested period, high time and burst
// length with a valid/ready handshake into the shadow register.
interface period_generator_if #(
   parameter int WIDTH   = 16,
   parameter int BURST_W = 8
);
   logic [WIDTH-1:0]   period_in;
   logic [WIDTH-1:0]   high_in;
   logic [BURST_W-1:0] burst_in;
   logic               load_valid;
   logic               load_ready;

   modport master (output period_in, high_in, burst_in, load_valid, input load_ready);
   modport slave  (input period_in, high_in, burst_in, load_valid, output load_ready);
endinterface

// File: rtl/period_generator.sv
// Programmable square-wave source on the 1 ms tick grid: period P ticks, high
// time H ticks, optional burst length; new settings take effect on period boundaries.
module period_generator #(
   parameter int WIDTH   = 16,
   parameter int BURST_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce1ms,
   input  logic              en,
   period_generator_if.slave load,
   output logic              sig,
   output logic              period_start,
   output logic              done,
   output logic              running
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]         state;
   logic [WIDTH-1:0]   cnt;
   logic [WIDTH-1:0]   p_act, h_act, p_sh, h_sh;
   logic [WIDTH-1:0]   p_new, h_new, h_eff;
   logic [BURST_W-1:0] b_act, b_sh, b_eff, left;
   logic               pending;
   logic               boundary, stop, apply;

   // NOTE: every signal written here gets a value on every path, so no latch is inferred.
   always_comb begin
      p_new    = (p_sh == '0) ? WIDTH'(1) : p_sh;
      h_new    = (h_sh > p_new) ? p_new : h_sh;
      boundary = (state == RUN) && (cnt == p_act - WIDTH'(1));
      stop     = boundary && (!en || (left == BURST_W'(1)));
      // In IDLE the shadow is taken on the next edge; in RUN only at a continuing boundary.
      apply    = pending && ((state == IDLE) || (ce1ms && boundary && !stop));
      h_eff    = apply ? h_new : h_act;
      b_eff    = apply ? b_sh : b_act;
   end

   assign load.load_ready = !pending;
   assign running         = (state == RUN);

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         p_act        <= WIDTH'(1);
         h_act        <= '0;
         b_act        <= '0;
         p_sh         <= '0;
         h_sh         <= '0;
         b_sh         <= '0;
         pending      <= 1'b0;
         left         <= '0;
         sig          <= 1'b0;
         period_start <= 1'b0;
         done         <= 1'b0;
      end else begin
         period_start <= 1'b0;
         done         <= 1'b0;

         if (load.load_valid && load.load_ready) begin
            p_sh    <= load.period_in;
            h_sh    <= load.high_in;
            b_sh    <= load.burst_in;
            pending <= 1'b1;
         end else if (apply) begin
            pending <= 1'b0;
         end

         if (apply) begin
            p_act <= p_new;
            h_act <= h_new;
            b_act <= b_sh;
         end

         if (ce1ms) begin
            case (state)
               IDLE: begin
                  if (en) begin
                     state        <= RUN;
                     cnt          <= '0;
                     sig          <= (h_eff != '0);
                     period_start <= 1'b1;
                     left         <= b_eff;
                  end else begin
                     sig <= 1'b0;
                  end
               end
               default: begin
                  if (!boundary) begin
                     cnt <= cnt + WIDTH'(1);
                     sig <= ((cnt + WIDTH'(1)) < h_act);
                  end else if (stop) begin
                     state <= IDLE;
                     cnt   <= '0;
                     sig   <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     cnt          <= '0;
                     sig          <= (h_eff != '0);
                     period_start <= 1'b1;
                     if (left != '0) left <= left - BURST_W'(1);
                  end
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_period_generator.sv
// Self-checking bench for period_generator: directed scenarios plus a randomized
// run, compared against a tick-position model of the waveform rules.
module tb_period_generator;
   localparam int WIDTH   = 16;
   localparam int BURST_W = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic ce1ms = 1'b0;
   logic en = 1'b0;
   logic sig, period_start, done, running;

   int errors = 0;
   int checks = 0;

   period_generator_if #(.WIDTH(WIDTH), .BURST_W(BURST_W)) load_bus ();

   period_generator #(.WIDTH(WIDTH), .BURST_W(BURST_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .ce1ms        (ce1ms),
      .en           (en),
      .load         (load_bus),
      .sig          (sig),
      .period_start (period_start),
      .done         (done),
      .running      (running)
   );

   always #5 clk = ~clk;

   // Reference model: active/shadow settings and position within the current period.
   int m_p = 1, m_h = 0, m_b = 0;
   int s_p = 0, s_h = 0, s_b = 0;
   int m_pos = 0, m_left = 0;
   bit m_pend = 0, m_run = 0, m_xfer = 0;
   bit e_sig = 0, e_ps = 0, e_done = 0;

   function automatic void take_shadow();
      m_p    = (s_p == 0) ? 1 : s_p;
      m_h    = (s_h > m_p) ? m_p : s_h;
      m_b    = s_b;
      m_pend = 0;
   endfunction

   function automatic void model_edge();
      bit had_pend;
      had_pend = m_pend;
      m_xfer   = 0;
      if (rst) begin
         m_p = 1; m_h = 0; m_b = 0; s_p = 0; s_h = 0; s_b = 0;
         m_pos = 0; m_left = 0; m_pend = 0; m_run = 0;
         e_sig = 0; e_ps = 0; e_done = 0;
         return;
      end
      e_ps   = 0;
      e_done = 0;
      m_xfer = load_bus.load_valid && !had_pend;
      if (!m_run) begin
         if (had_pend) take_shadow();
         if (ce1ms) begin
            if (en) begin
               m_run = 1; m_pos = 0; m_left = m_b; e_ps = 1; e_sig = (m_h > 0);
            end else begin
               e_sig = 0;
            end
         end
      end else if (ce1ms) begin
         if (m_pos + 1 < m_p) begin
            m_pos++;
            e_sig = (m_pos < m_h);
         end else if (!en || m_left == 1) begin
            m_run = 0; m_pos = 0; e_sig = 0; e_done = 1;
         end else begin
            if (had_pend) take_shadow();
            m_pos = 0; e_sig = (m_h > 0); e_ps = 1;
            if (m_left != 0) m_left--;
         end
      end
      if (m_xfer) begin
         s_p = int'(load_bus.period_in);
         s_h = int'(load_bus.high_in);
         s_b = int'(load_bus.burst_in);
         m_pend = 1;
      end
   endfunction

   function automatic logic [4:0] obs();
      return {sig, period_start, done, running, load_bus.load_ready};
   endfunction

   function automatic logic [4:0] exp_v();
      return {e_sig, e_ps, e_done, m_run, !m_pend};
   endfunction

   task automatic cyc(input bit tick);
      ce1ms = tick;
      model_edge();
      @(posedge clk);
      #1;
      if (m_xfer) load_bus.load_valid = 1'b0;
   endtask

   task automatic req_load(input int p, input int h, input int b);
      load_bus.period_in  = WIDTH'(p);
      load_bus.high_in    = WIDTH'(h);
      load_bus.burst_in   = BURST_W'(b);
      load_bus.load_valid = 1'b1;
   endtask

   task automatic setup(input int p, input int h, input int b);
      en = 1'b0;
      req_load(p, h, b);
      cyc(0);
      cyc(0);
   endtask

   task automatic stop_run();
      en = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (!running) break;
         cyc(0);
         cyc(1);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc(1);
      checks++;
      if (obs() !== 5'b00001) begin
         errors++; $display("FAIL reset_outputs: got %b expected %b", obs(), 5'b00001);
      end
      rst = 1'b0;
      cyc(0);
      checks++;
      if (obs() !== exp_v()) begin
         errors++; $display("FAIL reset_idle: got %b expected %b", obs(), exp_v());
      end
   endtask

   task automatic test_continuous();
      int last_rise;
      bit prev, want_sig, want_ps;
      last_rise = -1;
      prev = 0;
      setup(4, 2, 0);
      en = 1'b1;
      for (int k = 0; k < 12; k++) begin
         cyc(0);
         cyc(1);
         want_sig = ((k % 4) < 2);
         want_ps  = ((k % 4) == 0);
         checks++;
         if (obs() !== exp_v()) begin
            errors++; $display("FAIL cont_model k=%0d: got %b expected %b", k, obs(), exp_v());
         end
         checks++;
         if ({sig, period_start} !== {want_sig, want_ps}) begin
            errors++; $display("FAIL cont_pattern k=%0d: got %b%b expected %b%b",
                               k, sig, period_start, want_sig, want_ps);
         end
         if (sig && !prev) begin
            if (last_rise >= 0) begin
               checks++;
               if (k - last_rise != 4) begin
                  errors++; $display("FAIL cont_period: got %0d expected 4", k - last_rise);
               end
            end
            last_rise = k;
         end
         prev = sig;
      end
      stop_run();
      checks++;
      if (running !== 1'b0) begin
         errors++; $display("FAIL cont_stop: running got %b expected 0", running);
      end
   endtask

   task automatic test_burst();
      bit sig_tab [7] = '{1, 0, 0, 1, 0, 0, 0};
      setup(3, 1, 2);
      en = 1'b1;
      for (int k = 0; k < 7; k++) begin
         cyc(0);
         cyc(1);
         if (k == 6) en = 1'b0;
         checks++;
         if (obs() !== exp_v()) begin
            errors++; $display("FAIL burst_model k=%0d: got %b expected %b", k, obs(), exp_v());
         end
         checks++;
         if ({sig, done, period_start} !== {sig_tab[k], (k == 6), (k == 0 || k == 3)}) begin
            errors++; $display("FAIL burst_pattern k=%0d: got sig/done/ps %b%b%b expected %b%b%b",
                               k, sig, done, period_start, sig_tab[k], (k == 6), (k == 0 || k == 3));
         end
      end
      cyc(0);
      cyc(1);
      checks++;
      if ({running, sig} !== 2'b00) begin
         errors++; $display("FAIL burst_after: got running/sig %b%b expected 00", running, sig);
      end
   endtask

   task automatic test_midrun_load();
      bit sig_tab [10] = '{1, 1, 0, 0, 0, 1, 0, 1, 0, 1};
      bit want_ready, want_ps;
      setup(5, 2, 0);
      en = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (k == 3) req_load(2, 1, 0);
         cyc(0);
         checks++;
         if (obs() !== exp_v()) begin
            errors++; $display("FAIL midrun_gap k=%0d: got %b expected %b", k, obs(), exp_v());
         end
         cyc(1);
         want_ready = !(k == 3 || k == 4);
         want_ps    = (k == 0 || k == 5 || k == 7 || k == 9);
         checks++;
         if ({sig, period_start, load_bus.load_ready} !== {sig_tab[k], want_ps, want_ready}) begin
            errors++; $display("FAIL midrun_tick k=%0d: got sig/ps/ready %b%b%b expected %b%b%b",
                               k, sig, period_start, load_bus.load_ready,
                               sig_tab[k], want_ps, want_ready);
         end
      end
      stop_run();
      checks++;
      if (running !== 1'b0) begin
         errors++; $display("FAIL midrun_stop: running got %b expected 0", running);
      end
   endtask

   task automatic test_clamp();
      setup(0, 7, 0);
      en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cyc(0);
         cyc(1);
         checks++;
         if ({sig, period_start} !== 2'b11 || obs() !== exp_v()) begin
            errors++; $display("FAIL clamp_p1h1 k=%0d: got %b expected sig/ps 11", k, obs());
         end
      end
      req_load(0, 0, 0);
      for (int k = 0; k < 5; k++) begin
         cyc(0);
         cyc(1);
         checks++;
         if ({sig, period_start} !== 2'b01 || obs() !== exp_v()) begin
            errors++; $display("FAIL clamp_h0 k=%0d: got %b expected sig/ps 01", k, obs());
         end
      end
      req_load(16'hFFFF, 16'hFFFF, 0);
      for (int k = 0; k < 6; k++) begin
         cyc(0);
         cyc(1);
         checks++;
         if ({sig, period_start} !== {1'b1, (k == 0)} || obs() !== exp_v()) begin
            errors++; $display("FAIL clamp_max k=%0d: got %b expected sig/ps 1%b", k, obs(), (k == 0));
         end
      end
      en  = 1'b0;
      rst = 1'b1;
      cyc(0);
      rst = 1'b0;
   endtask

   task automatic test_en_drop();
      bit sig_tab [5] = '{1, 1, 1, 0, 0};
      setup(4, 3, 0);
      en = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cyc(0);
         cyc(1);
         if (k == 1) en = 1'b0;
         checks++;
         if ({sig, done, running} !== {sig_tab[k], (k == 4), (k != 4)} || obs() !== exp_v()) begin
            errors++; $display("FAIL en_drop k=%0d: got sig/done/running %b%b%b expected %b%b%b",
                               k, sig, done, running, sig_tab[k], (k == 4), (k != 4));
         end
      end
   endtask

   task automatic test_reset_midrun();
      setup(5, 2, 0);
      en = 1'b1;
      cyc(1);
      cyc(1);
      req_load(2, 1, 3);
      cyc(0);
      checks++;
      if (load_bus.load_ready !== 1'b0) begin
         errors++; $display("FAIL rstmid_pending: ready got %b expected 0", load_bus.load_ready);
      end
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      load_bus.load_valid = 1'b0;
      checks++;
      if (obs() !== 5'b00001) begin
         errors++; $display("FAIL rstmid_outputs: got %b expected %b", obs(), 5'b00001);
      end
      cyc(0);
      cyc(1);
      checks++;
      if ({sig, period_start, running} !== 3'b011 || obs() !== exp_v()) begin
         errors++; $display("FAIL rstmid_defaults: got %b expected sig/ps/running 011", obs());
      end
      cyc(1);
      checks++;
      if ({sig, period_start} !== 2'b01) begin
         errors++; $display("FAIL rstmid_p1: got sig/ps %b%b expected 01", sig, period_start);
      end
      stop_run();
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(199) == 0);
         if ($urandom_range(39) == 0) en = ~en;
         if (!load_bus.load_valid && $urandom_range(24) == 0)
            req_load($urandom_range(6), $urandom_range(7), $urandom_range(3));
         cyc($urandom_range(2) == 0);
         checks++;
         if (obs() !== exp_v()) begin
            errors++; $display("FAIL random i=%0d: got %b expected %b", i, obs(), exp_v());
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      load_bus.period_in  = '0;
      load_bus.high_in    = '0;
      load_bus.burst_in   = '0;
      load_bus.load_valid = 1'b0;
      test_reset();
      test_continuous();
      test_burst();
      test_midrun_load();
      test_clamp();
      test_en_drop();
      test_reset_midrun();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
